id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 The block SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  PC of the ID instruction
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  5  register addresses
- id_funct3_i  in  3  branch/load/store sub-type
- id_RegWrite_i, id_ALUSrc_i, id_MemWrite_i, id_MemToReg_i, id_Branch_i, id_MemRead_i  in  1 each  decoder controls
- id_ALUControl_i  in  4  ALU operation
- flush_i  in  1  branch taken/redirect; kill ID instruction
- hold_i  in  1  global freeze (data-memory wait)
- ex_* outputs  out  same widths as the id_* inputs, plus ex_valid_o (1)  registered EX-stage copies
- stall_o  out  1  freeze PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted

Function
REQ-005 stall_o SHALL be combinational: id_valid_i & ex_valid_o & ex_MemRead_o & (ex_rd_o != 0) & ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)).
REQ-006 stall_o SHALL NOT depend on hold_i or flush_i.
REQ-007 Register-update priority per rising edge SHALL be rst, then flush_i, then hold_i, then stall_o, then normal capture.
REQ-008 On flush_i, the block SHALL load a bubble: ex_valid_o=0, all six 1-bit controls=0, ex_ALUControl_o=0 (ADD), ex_rd_o=0; data and address fields are don't-care but SHALL be zeroed.
REQ-009 Under hold_i (no flush), all ex_* registers and bubble_cnt_o SHALL keep their values.
REQ-010 Under stall_o (no flush, no hold), the block SHALL load the bubble of REQ-008 and increment bubble_cnt_o by 1.
REQ-011 Otherwise the block SHALL capture every id_* input into its ex_* register, with ex_valid_o=id_valid_i; latency is exactly 1 cycle.
REQ-012 When id_valid_i=0 on capture, all control outputs SHALL be forced to 0 so an invalid slot never writes the register file or memory.
REQ-013 A load-use hazard SHALL produce exactly one bubble: the bubble leaves ex_MemRead_o=0 on the next cycle, so stall_o deasserts.
REQ-014 bubble_cnt_o SHALL saturate at all-ones and never wrap.
REQ-015 flush_i and stall_o in the same cycle SHALL load one bubble and SHALL NOT increment bubble_cnt_o.
REQ-016 A hazard on rd=x0 SHALL NOT stall.

Reset
REQ-017 On rst, all ex_* outputs and bubble_cnt_o SHALL be 0 on the next edge, overriding flush_i and hold_i.
REQ-018 stall_o SHALL be 0 from the cycle after reset, since ex_valid_o=0, until a valid load is captured.

Structure
REQ-019 The XLEN default, the ALU ADD encoding and the bubble control constant SHALL live in the shared package riscv_pkg.
REQ-020 The stall_o equation SHALL be a sub-module named hazard_detect; the register bank SHALL stay in id_ex_stage.

Verification
REQ-021 Normal capture: a valid ADD (RegWrite=1, ALUControl=0, rd=5, rs1_data=0x10) -> next cycle ex_valid_o=1, ex_rd_o=5, ex_rs1_data_o=0x10.
REQ-022 Load-use: a LW to x5 in EX (ex_MemRead_o=1, ex_rd_o=5) and an ADD reading x5 in ID ->
- stall_o=1 for exactly one cycle;
- the next EX is a bubble;
- bubble_cnt_o increments 0->1;
- the following cycle the ADD is captured.
REQ-023 x0 guard: a LW to x0 followed by a consumer of x0 -> stall_o stays 0 and bubble_cnt_o does not change.
REQ-024 Flush+stall: flush_i=1 in the same cycle as a load-use hazard -> a bubble is loaded and bubble_cnt_o is unchanged.
REQ-025 Hold: hold_i=1 for 3 cycles while the ID inputs change -> the ex_* outputs stay frozen; after release the current ID values are captured.
REQ-026 Saturation and reset:
- preload bubble_cnt_o to 0xFFFF, then force a hazard -> bubble_cnt_o stays 0xFFFF;
- rst asserted mid-stream with flush_i=1 -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width default, ALU encodings and
// the decoder control bundle with its bubble value.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int FUNCT3_W     = 3;
  localparam int ALU_CTRL_W   = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;

  typedef struct packed {
    logic                  reg_write;
    logic                  alu_src;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  branch;
    logic                  mem_read;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } ctrl_t;

  // A bubble is a harmless ADD that writes nothing and touches no memory.
  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write:  1'b0,
    alu_src:    1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    branch:     1'b0,
    mem_read:   1'b0,
    alu_ctrl:   ALU_ADD
  };

  function automatic ctrl_t gate_ctrl(input ctrl_t ctrl, input logic valid);
    return valid ? ctrl : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: asks for a one-cycle stall when the load in EX
// writes a register that the instruction in ID reads.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  output logic                  stall_o
);

  logic rd_nonzero_s;
  logic rd_match_s;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign rd_nonzero_s = (ex_rd_i != {REG_ADDR_W{1'b0}});
  assign rd_match_s   = (ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i);
  assign stall_o      = id_valid_i & ex_valid_i & ex_mem_read_i & rd_nonzero_s & rd_match_s;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register bank with flush, global hold, load-use bubble
// insertion and a saturating count of inserted bubbles.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [FUNCT3_W-1:0]   id_funct3_i,
  input  logic                  id_RegWrite_i,
  input  logic                  id_ALUSrc_i,
  input  logic                  id_MemWrite_i,
  input  logic                  id_MemToReg_i,
  input  logic                  id_Branch_i,
  input  logic                  id_MemRead_i,
  input  logic [ALU_CTRL_W-1:0] id_ALUControl_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic                  ex_valid_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [XLEN-1:0]       ex_imm_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [FUNCT3_W-1:0]   ex_funct3_o,
  output logic                  ex_RegWrite_o,
  output logic                  ex_ALUSrc_o,
  output logic                  ex_MemWrite_o,
  output logic                  ex_MemToReg_o,
  output logic                  ex_Branch_o,
  output logic                  ex_MemRead_o,
  output logic [ALU_CTRL_W-1:0] ex_ALUControl_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  logic                  valid_q,    valid_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic [FUNCT3_W-1:0]   funct3_q,   funct3_d;
  ctrl_t                 ctrl_q,     ctrl_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;

  ctrl_t id_ctrl_s;
  logic  stall_s;

  assign id_ctrl_s = '{
    reg_write:  id_RegWrite_i,
    alu_src:    id_ALUSrc_i,
    mem_write:  id_MemWrite_i,
    mem_to_reg: id_MemToReg_i,
    branch:     id_Branch_i,
    mem_read:   id_MemRead_i,
    alu_ctrl:   id_ALUControl_i
  };

  hazard_detect u_hazard_detect (
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .stall_o       (stall_s)
  );

  // Next-state selection: flush beats hold beats load-use stall beats capture.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    if (flush_i || (!hold_i && stall_s)) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      funct3_d   = '0;
      ctrl_d     = CTRL_BUBBLE;
      // Only a real load-use bubble is counted; a flush absorbs any coincident stall.
      if (!flush_i && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else begin
      valid_d    = id_valid_i;
      pc_d       = id_pc_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      rs1_d      = id_rs1_i;
      rs2_d      = id_rs2_i;
      rd_d       = id_rd_i;
      funct3_d   = id_funct3_i;
      ctrl_d     = gate_ctrl(id_ctrl_s, id_valid_i);
    end
  end

  // Pipeline register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      ctrl_q     <= CTRL_BUBBLE;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid_o      = valid_q;
  assign ex_pc_o         = pc_q;
  assign ex_rs1_data_o   = rs1_data_q;
  assign ex_rs2_data_o   = rs2_data_q;
  assign ex_imm_o        = imm_q;
  assign ex_rs1_o        = rs1_q;
  assign ex_rs2_o        = rs2_q;
  assign ex_rd_o         = rd_q;
  assign ex_funct3_o     = funct3_q;
  assign ex_RegWrite_o   = ctrl_q.reg_write;
  assign ex_ALUSrc_o     = ctrl_q.alu_src;
  assign ex_MemWrite_o   = ctrl_q.mem_write;
  assign ex_MemToReg_o   = ctrl_q.mem_to_reg;
  assign ex_Branch_o     = ctrl_q.branch;
  assign ex_MemRead_o    = ctrl_q.mem_read;
  assign ex_ALUControl_o = ctrl_q.alu_ctrl;
  assign stall_o         = stall_s;
  assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage; a second narrow-counter
// instance shares the stimulus to reach counter saturation quickly.
module tb_id_ex_stage;

  localparam logic [9:0] C_ADD = 10'h200;
  localparam logic [9:0] C_SUB = 10'h201;
  localparam logic [9:0] C_LW  = 10'h350;
  localparam logic [9:0] C_SW  = 10'h180;
  localparam logic [9:0] C_BEQ = 10'h021;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush_i, hold_i, id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0]  id_funct3_i;
  logic        id_RegWrite_i, id_ALUSrc_i, id_MemWrite_i, id_MemToReg_i, id_Branch_i, id_MemRead_i;
  logic [3:0]  id_ALUControl_i;

  logic        ex_valid_o, ex_RegWrite_o, ex_ALUSrc_o, ex_MemWrite_o, ex_MemToReg_o, ex_Branch_o, ex_MemRead_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [3:0]  ex_ALUControl_o;
  logic        stall_o;
  logic [15:0] bubble_cnt_o;

  logic        s_valid, s_RegWrite, s_ALUSrc, s_MemWrite, s_MemToReg, s_Branch, s_MemRead;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_funct3;
  logic [3:0]  s_ALUControl;
  logic        s_stall;
  logic [1:0]  s_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct3_i(id_funct3_i),
    .id_RegWrite_i(id_RegWrite_i), .id_ALUSrc_i(id_ALUSrc_i), .id_MemWrite_i(id_MemWrite_i),
    .id_MemToReg_i(id_MemToReg_i), .id_Branch_i(id_Branch_i), .id_MemRead_i(id_MemRead_i),
    .id_ALUControl_i(id_ALUControl_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_rd_o(ex_rd_o), .ex_funct3_o(ex_funct3_o), .ex_RegWrite_o(ex_RegWrite_o),
    .ex_ALUSrc_o(ex_ALUSrc_o), .ex_MemWrite_o(ex_MemWrite_o), .ex_MemToReg_o(ex_MemToReg_o),
    .ex_Branch_o(ex_Branch_o), .ex_MemRead_o(ex_MemRead_o), .ex_ALUControl_o(ex_ALUControl_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct3_i(id_funct3_i),
    .id_RegWrite_i(id_RegWrite_i), .id_ALUSrc_i(id_ALUSrc_i), .id_MemWrite_i(id_MemWrite_i),
    .id_MemToReg_i(id_MemToReg_i), .id_Branch_i(id_Branch_i), .id_MemRead_i(id_MemRead_i),
    .id_ALUControl_i(id_ALUControl_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid_o(s_valid), .ex_pc_o(s_pc), .ex_rs1_data_o(s_rs1_data),
    .ex_rs2_data_o(s_rs2_data), .ex_imm_o(s_imm), .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2),
    .ex_rd_o(s_rd), .ex_funct3_o(s_funct3), .ex_RegWrite_o(s_RegWrite),
    .ex_ALUSrc_o(s_ALUSrc), .ex_MemWrite_o(s_MemWrite), .ex_MemToReg_o(s_MemToReg),
    .ex_Branch_o(s_Branch), .ex_MemRead_o(s_MemRead), .ex_ALUControl_o(s_ALUControl),
    .stall_o(s_stall), .bubble_cnt_o(s_cnt)
  );

  typedef struct {
    string       nm;
    logic        rst, flush, hold, valid;
    logic [31:0] pc, rs1d;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  ctrl;
    logic        e_stall, e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_rs1d, e_pc;
    logic [9:0]  e_ctrl;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic f, input logic h,
                              input logic v, input logic [31:0] pc, input logic [31:0] rs1d,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [9:0] ctrl, input logic es, input logic ev,
                              input logic [4:0] erd, input logic [31:0] ers1d,
                              input logic [31:0] epc, input logic [9:0] ectrl,
                              input logic [15:0] ecnt);
    vec_t t;
    t.nm = nm; t.rst = r; t.flush = f; t.hold = h; t.valid = v;
    t.pc = pc; t.rs1d = rs1d; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.ctrl = ctrl;
    t.e_stall = es; t.e_valid = ev; t.e_rd = erd; t.e_rs1d = ers1d; t.e_pc = epc;
    t.e_ctrl = ectrl; t.e_cnt = ecnt;
    return t;
  endfunction

  function automatic logic [9:0] act_ctrl();
    return {ex_RegWrite_o, ex_ALUSrc_o, ex_MemWrite_o, ex_MemToReg_o, ex_Branch_o,
            ex_MemRead_o, ex_ALUControl_o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rs1d,
                        input logic [31:0] rs2d, input logic [31:0] imm, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [9:0] ctrl);
    id_valid_i = v; id_pc_i = pc; id_rs1_data_i = rs1d; id_rs2_data_i = rs2d; id_imm_i = imm;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_funct3_i = f3;
    {id_RegWrite_i, id_ALUSrc_i, id_MemWrite_i, id_MemToReg_i, id_Branch_i, id_MemRead_i,
     id_ALUControl_i} = ctrl;
  endtask

  task automatic chk_all(input string nm, input logic v, input logic [31:0] pc,
                         input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [9:0] ctrl);
    chk({nm, ".valid"}, ex_valid_o, v);
    chk({nm, ".pc"}, ex_pc_o, pc);
    chk({nm, ".rs1_data"}, ex_rs1_data_o, rs1d);
    chk({nm, ".rs2_data"}, ex_rs2_data_o, rs2d);
    chk({nm, ".imm"}, ex_imm_o, imm);
    chk({nm, ".rs1"}, ex_rs1_o, rs1);
    chk({nm, ".rs2"}, ex_rs2_o, rs2);
    chk({nm, ".rd"}, ex_rd_o, rd);
    chk({nm, ".funct3"}, ex_funct3_o, f3);
    chk({nm, ".ctrl"}, act_ctrl(), ctrl);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; flush_i = v.flush; hold_i = v.hold;
    set_id(v.valid, v.pc, v.rs1d, v.rs1d ^ 32'hFFFF_0000, v.pc + 32'h8, v.rs1, v.rs2, v.rd,
           3'b010, v.ctrl);
    #1;
    chk({v.nm, ".stall"}, stall_o, v.e_stall);
    @(posedge clk);
    #1;
    chk({v.nm, ".valid"}, ex_valid_o, v.e_valid);
    chk({v.nm, ".rd"}, ex_rd_o, v.e_rd);
    chk({v.nm, ".rs1_data"}, ex_rs1_data_o, v.e_rs1d);
    chk({v.nm, ".pc"}, ex_pc_o, v.e_pc);
    chk({v.nm, ".ctrl"}, act_ctrl(), v.e_ctrl);
    chk({v.nm, ".cnt"}, bubble_cnt_o, v.e_cnt);
    chk({v.nm, ".cnt_narrow"}, s_cnt, (v.e_cnt > 16'd3) ? 16'd3 : v.e_cnt);
  endtask

  initial begin
    //            name           rst   fl    hd    vld   pc       rs1d    rs1   rs2    rd     ctrl   stl   e_v   e_rd   e_rs1d  e_pc    e_ctrl e_cnt
    tbl.push_back(mk("add_cap",     1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h10, 5'd1, 5'd2,  5'd5,  C_ADD, 1'b0, 1'b1, 5'd5,  32'h10, 32'h100, C_ADD, 16'd0));
    tbl.push_back(mk("lw_cap",      1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 32'h20, 5'd2, 5'd0,  5'd5,  C_LW,  1'b0, 1'b1, 5'd5,  32'h20, 32'h104, C_LW,  16'd0));
    tbl.push_back(mk("lu_bubble",   1'b0, 1'b0, 1'b0, 1'b1, 32'h108, 32'h30, 5'd5, 5'd3,  5'd6,  C_ADD, 1'b1, 1'b0, 5'd0,  32'h0,  32'h0,   10'h0, 16'd1));
    tbl.push_back(mk("lu_release",  1'b0, 1'b0, 1'b0, 1'b1, 32'h108, 32'h30, 5'd5, 5'd3,  5'd6,  C_ADD, 1'b0, 1'b1, 5'd6,  32'h30, 32'h108, C_ADD, 16'd1));
    tbl.push_back(mk("lw_x0",       1'b0, 1'b0, 1'b0, 1'b1, 32'h10C, 32'h40, 5'd1, 5'd0,  5'd0,  C_LW,  1'b0, 1'b1, 5'd0,  32'h40, 32'h10C, C_LW,  16'd1));
    tbl.push_back(mk("x0_use",      1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 32'h50, 5'd0, 5'd0,  5'd7,  C_ADD, 1'b0, 1'b1, 5'd7,  32'h50, 32'h110, C_ADD, 16'd1));
    tbl.push_back(mk("lw_x9",       1'b0, 1'b0, 1'b0, 1'b1, 32'h114, 32'h60, 5'd1, 5'd2,  5'd9,  C_LW,  1'b0, 1'b1, 5'd9,  32'h60, 32'h114, C_LW,  16'd1));
    tbl.push_back(mk("flush_stall", 1'b0, 1'b1, 1'b0, 1'b1, 32'h118, 32'h70, 5'd3, 5'd9,  5'd0,  C_SW,  1'b1, 1'b0, 5'd0,  32'h0,  32'h0,   10'h0, 16'd1));
    tbl.push_back(mk("inval_gate",  1'b0, 1'b0, 1'b0, 1'b0, 32'h11C, 32'h80, 5'd1, 5'd2,  5'd4,  C_LW,  1'b0, 1'b0, 5'd4,  32'h80, 32'h11C, 10'h0, 16'd1));
    tbl.push_back(mk("lw_x3",       1'b0, 1'b0, 1'b0, 1'b1, 32'h120, 32'h90, 5'd1, 5'd2,  5'd3,  C_LW,  1'b0, 1'b1, 5'd3,  32'h90, 32'h120, C_LW,  16'd1));
    tbl.push_back(mk("inval_use",   1'b0, 1'b0, 1'b0, 1'b0, 32'h124, 32'hA0, 5'd3, 5'd0,  5'd8,  C_ADD, 1'b0, 1'b0, 5'd8,  32'hA0, 32'h124, 10'h0, 16'd1));
    tbl.push_back(mk("lw_x12",      1'b0, 1'b0, 1'b0, 1'b1, 32'h128, 32'hB0, 5'd1, 5'd2,  5'd12, C_LW,  1'b0, 1'b1, 5'd12, 32'hB0, 32'h128, C_LW,  16'd1));
    tbl.push_back(mk("hold_stall",  1'b0, 1'b0, 1'b1, 1'b1, 32'h12C, 32'hC0, 5'd4, 5'd12, 5'd0,  C_BEQ, 1'b1, 1'b1, 5'd12, 32'hB0, 32'h128, C_LW,  16'd1));
    tbl.push_back(mk("stall_after", 1'b0, 1'b0, 1'b0, 1'b1, 32'h12C, 32'hC0, 5'd4, 5'd12, 5'd0,  C_BEQ, 1'b1, 1'b0, 5'd0,  32'h0,  32'h0,   10'h0, 16'd2));
    tbl.push_back(mk("beq_cap",     1'b0, 1'b0, 1'b0, 1'b1, 32'h12C, 32'hC0, 5'd4, 5'd12, 5'd0,  C_BEQ, 1'b0, 1'b1, 5'd0,  32'hC0, 32'h12C, C_BEQ, 16'd2));
    tbl.push_back(mk("flush_hold",  1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h55, 5'd1, 5'd2,  5'd7,  C_ADD, 1'b0, 1'b0, 5'd0,  32'h0,  32'h0,   10'h0, 16'd2));
    tbl.push_back(mk("lw_x5",       1'b0, 1'b0, 1'b0, 1'b1, 32'h130, 32'hD0, 5'd1, 5'd2,  5'd5,  C_LW,  1'b0, 1'b1, 5'd5,  32'hD0, 32'h130, C_LW,  16'd2));
    tbl.push_back(mk("rst_flush",   1'b1, 1'b1, 1'b0, 1'b1, 32'h134, 32'hE0, 5'd5, 5'd0,  5'd6,  C_ADD, 1'b1, 1'b0, 5'd0,  32'h0,  32'h0,   10'h0, 16'd0));
    tbl.push_back(mk("post_rst",    1'b0, 1'b0, 1'b0, 1'b1, 32'h138, 32'hF0, 5'd5, 5'd0,  5'd6,  C_ADD, 1'b0, 1'b1, 5'd6,  32'hF0, 32'h138, C_ADD, 16'd0));

    // Reset overrides hold and a valid load presented in ID.
    rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 10'h0);
    @(posedge clk);
    @(negedge clk);
    hold_i = 1'b1;
    set_id(1'b1, 32'h44, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 3'b010, C_LW);
    @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 10'h0);
    chk("reset.cnt", bubble_cnt_o, 16'd0);
    chk("reset.stall", stall_o, 1'b0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Hold for three cycles while ID changes, then release.
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    set_id(1'b1, 32'h300, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd10, 3'b101, C_SUB);
    @(posedge clk);
    #1;
    chk_all("hold_base", 1'b1, 32'h300, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd10, 3'b101, C_SUB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hold_i = 1'b1;
      set_id(1'b1, 32'h400 + 32'(k * 4), 32'h44 + 32'(k), 32'h66, 32'h77, 5'd3, 5'd4,
             5'(11 + k), 3'(k), C_ADD);
      @(posedge clk);
      #1;
      chk_all("hold_frozen", 1'b1, 32'h300, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd10, 3'b101, C_SUB);
    end
    @(negedge clk);
    hold_i = 1'b0;
    set_id(1'b1, 32'h500, 32'h55, 32'h66, 32'h77, 5'd7, 5'd8, 5'd13, 3'b110, C_BEQ);
    @(posedge clk);
    #1;
    chk_all("hold_release", 1'b1, 32'h500, 32'h55, 32'h66, 32'h77, 5'd7, 5'd8, 5'd13, 3'b110, C_BEQ);
    chk("hold_release.cnt", bubble_cnt_o, 16'd0);

    // Four load-use bubbles: the 2-bit counter must stop at 3 rather than wrap.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_id(1'b1, 32'h600, 32'h1, 32'h2, 32'h4, 5'd1, 5'd2, 5'd5, 3'b010, C_LW);
      #1;
      chk("sat_lw.stall", stall_o, 1'b0);
      @(posedge clk);
      @(negedge clk);
      set_id(1'b1, 32'h604, 32'h3, 32'h4, 32'h8, 5'd5, 5'd2, 5'd6, 3'b000, C_ADD);
      #1;
      chk("sat_use.stall", stall_o, 1'b1);
      @(posedge clk);
      #1;
      chk("sat.cnt", bubble_cnt_o, 16'(k + 1));
      chk("sat.cnt_narrow", s_cnt, (k >= 2) ? 2'd3 : 2'(k + 1));
      chk("sat.bubble_valid", ex_valid_o, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("sat_after.stall", stall_o, 1'b0);
    @(posedge clk);
    #1;
    chk("sat_after.valid", ex_valid_o, 1'b1);
    chk("sat_after.rd", ex_rd_o, 5'd6);
    chk("sat_after.cnt_narrow", s_cnt, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
